// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : stage_mem_lsu
//  Description : Pipelined memory stage between execute and write-back.
//                Issues loads/stores on a req/gnt + rvalid bus with up to
//                DEPTH ops in flight, retires in program order through a
//                completion queue, formats load data, traps misaligned
//                accesses and resolves jumps/branches.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_mem_lsu #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    // execute side
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_data0,
    input  logic [XLEN-1:0] mem_data1,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_extend,
    input  logic [1:0]      mem_width,
    input  logic            mem_jmp,
    input  logic            mem_br,
    input  logic            mem_br_inv,
    input  logic [4:0]      mem_rd,
    output logic            mem_stall,
    // data bus
    output logic            req,
    output logic [XLEN-1:0] addr,
    output logic            write,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    input  logic            gnt,
    input  logic            rvalid,
    input  logic [XLEN-1:0] rdata,
    // fetch redirect
    output logic            fe_enable,
    output logic            pc_wen,
    output logic [XLEN-1:0] pc,
    // decode bypass
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_wen,
    // write-back side
    input  logic            wb_stall,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_exc
);

    localparam int               c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_depth  = (c_ptr_w + 1)'(DEPTH);
    localparam logic [1:0]       c_w_byte = 2'd0;
    localparam logic [1:0]       c_w_half = 2'd1;

    // ------------------------------------------------------------------
    // Completion queue storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    r_pc    [DEPTH];
    logic [XLEN-1:0]    r_data  [DEPTH];
    logic [4:0]         r_rd    [DEPTH];
    logic [1:0]         r_width [DEPTH];
    logic [1:0]         r_a     [DEPTH];
    logic [DEPTH-1:0]   r_ext;
    logic [DEPTH-1:0]   r_load;
    logic [DEPTH-1:0]   r_done;
    logic [DEPTH-1:0]   r_exc;
    logic [DEPTH-1:0]   r_pend;     // issued to the bus, response outstanding
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;
    logic               r_after_rst; // stale responses may still arrive

    logic               w_memop;
    logic               w_is_load;
    logic               w_mis;
    logic               w_room;
    logic               w_acc;
    logic               w_retire;
    logic [1:0]         w_a;
    logic               w_has_pend;
    logic [c_ptr_w-1:0] w_resp;
    logic [XLEN-1:0]    w_shift;
    logic [XLEN-1:0]    w_ldata;

    // Decode the presented op and decide whether it is accepted this cycle
    always_comb begin
        w_a       = mem_data0[1:0];
        w_memop   = mem_read | mem_write;
        w_is_load = mem_read & ~mem_write;
        if (mem_width == c_w_byte) begin
            w_mis = 1'b0;
        end else if (mem_width == c_w_half) begin
            w_mis = w_a[0];
        end else begin
            w_mis = (w_a != 2'b00);
        end
        w_mis     = w_mis & w_memop;
        // a full queue blocks even when the head retires this same cycle
        w_room    = (r_count < c_depth);
        w_acc     = ~reset & mem_valid & w_room & (~w_memop | w_mis | gnt);
        mem_stall = mem_valid & ~w_acc;
        req       = ~reset & mem_valid & w_memop & ~w_mis & w_room;
    end

    // Bus address, byte enables and lane-replicated store data
    always_comb begin
        addr  = {mem_data0[XLEN-1:2], 2'b00};
        write = mem_write;
        if (mem_width == c_w_byte) begin
            be    = 4'b0001 << w_a;
            wdata = XLEN'({4{mem_data1[7:0]}});
        end else if (mem_width == c_w_half) begin
            be    = 4'b0011 << w_a;
            wdata = XLEN'({2{mem_data1[15:0]}});
        end else begin
            be    = 4'b1111;
            wdata = mem_data1;
        end
    end

    // Jump/branch resolution and bypass of non-memory results
    always_comb begin
        fe_enable = w_acc & (mem_jmp | mem_br);
        pc_wen    = w_acc & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
        pc        = mem_data1;
        fwd_wen   = w_acc & ~w_memop;
        fwd_rd    = mem_rd;
        fwd_data  = mem_data0;
    end

    // Locate the oldest live entry still waiting for a bus response
    always_comb begin
        w_has_pend = 1'b0;
        w_resp     = r_head;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (((c_ptr_w + 1)'(i) < r_count) && r_pend[r_head + c_ptr_w'(i)]) begin
                w_has_pend = 1'b1;
                w_resp     = r_head + c_ptr_w'(i);
            end
        end
    end

    // Align the returned word to the access offset and extend to XLEN
    always_comb begin
        w_shift = rdata >> {r_a[w_resp], 3'b000};
        if (r_width[w_resp] == c_w_byte) begin
            w_ldata = {{(XLEN-8){r_ext[w_resp] & w_shift[7]}}, w_shift[7:0]};
        end else if (r_width[w_resp] == c_w_half) begin
            w_ldata = {{(XLEN-16){r_ext[w_resp] & w_shift[15]}}, w_shift[15:0]};
        end else begin
            w_ldata = w_shift;
        end
    end

    // Head retirement towards write-back
    always_comb begin
        w_retire = ~reset & (r_count != '0) & r_done[r_head] & ~wb_stall;
        wb_valid = w_retire;
        wb_pc    = r_pc[r_head];
        wb_rd    = r_rd[r_head];
        wb_data  = r_data[r_head];
        wb_exc   = w_retire & r_exc[r_head];
    end

    // Queue control: pointers, occupancy and per-entry status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_done      <= '0;
            r_pend      <= '0;
            r_exc       <= '0;
            r_after_rst <= 1'b1;
        end else begin
            if (w_acc) begin
                r_tail         <= r_tail + c_ptr_w'(1);
                r_done[r_tail] <= ~w_memop | w_mis;
                r_pend[r_tail] <= w_memop & ~w_mis;
                r_exc[r_tail]  <= w_mis;
            end
            if (rvalid && w_has_pend) begin
                r_done[w_resp] <= 1'b1;
                r_pend[w_resp] <= 1'b0;
            end
            if (w_retire) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w + 1)'(w_acc) - (c_ptr_w + 1)'(w_retire);
            if (req && gnt) begin
                r_after_rst <= 1'b0;
            end
        end
    end

    // Entry payload: captured at accept, load data filled on response
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_acc) begin
                r_pc[r_tail]    <= mem_pc;
                r_rd[r_tail]    <= (w_mis | mem_write) ? 5'd0 : mem_rd;
                r_width[r_tail] <= mem_width;
                r_a[r_tail]     <= w_a;
                r_ext[r_tail]   <= mem_extend;
                r_load[r_tail]  <= w_is_load;
                r_data[r_tail]  <= w_memop ? '0 : mem_data0;
            end
            if (rvalid && w_has_pend && r_load[w_resp]) begin
                r_data[w_resp] <= w_ldata;
            end
        end
    end

    // A response with nothing outstanding is a bus protocol error, except for
    // stragglers from requests issued before the last reset.
    a_rvalid_has_owner : assert property (@(posedge clk) disable iff (reset)
        !(rvalid && !w_has_pend && !r_after_rst));

endmodule
`default_nettype wire
